// File: rtl/lsu_bus_master_if.sv
// Request/grant/response data bus between the load/store unit and memory.
// The master drives the request fields; the slave returns grant and response.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit: one bus access per memory instruction, pipeline stalled until
// completion, aligned/extended load data on rdata3, reject and timeout flags.
//
// state | meaning
// IDLE  | waiting for a legal, aligned mem_req
// REQ   | bus_req held with stable fields until bus_gnt
// WAIT  | granted, waiting for bus_rvalid
// DONE  | one-cycle completion (lsu_done, optional bus_fault)
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             stall,
    output logic             lsu_done,
    output logic [31:0]      rdata3,
    output logic             misaligned,
    output logic             illegal,
    output logic             bus_fault,
    lsu_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic             lsu_done_q, lsu_done_d;
    logic             bus_fault_q, bus_fault_d;
    logic [31:0]      rdata3_q, rdata3_d;

    logic        illegal_chk;
    logic        misalign_chk;
    logic        launch;
    logic        expired;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // An illegal encoding is reported as illegal only, never also as misaligned.
    always_comb begin
        illegal_chk  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_we && funct3[2]);
        misalign_chk = !illegal_chk &&
                       (((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
        launch       = (state_q == IDLE) && mem_req && !illegal_chk && !misalign_chk;
        expired      = (cnt_q >= CNT_LAST);
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << addr[1:0];
                wdata_n = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!mem_we) begin
            wdata_n = 32'h0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        lsu_done_d  = 1'b0;
        bus_fault_d = 1'b0;
        rdata3_d    = rdata3_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_n;
                    bus_wdata_d = wdata_n;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.bus_gnt && bus.bus_rvalid) begin
                    bus_req_d  = 1'b0;
                    lsu_done_d = 1'b1;
                    state_d    = DONE;
                    if (!bus_we_q) begin
                        rdata3_d = fmt_load(bus.bus_rdata, off_q, funct3_q);
                    end
                end else if (expired) begin
                    bus_req_d   = 1'b0;
                    lsu_done_d  = 1'b1;
                    bus_fault_d = 1'b1;
                    state_d     = DONE;
                    if (!bus_we_q) begin
                        rdata3_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.bus_gnt) begin
                        bus_req_d = 1'b0;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response in the final allowed cycle still completes normally.
                if (bus.bus_rvalid) begin
                    lsu_done_d = 1'b1;
                    state_d    = DONE;
                    if (!bus_we_q) begin
                        rdata3_d = fmt_load(bus.bus_rdata, off_q, funct3_q);
                    end
                end else if (expired) begin
                    lsu_done_d  = 1'b1;
                    bus_fault_d = 1'b1;
                    state_d     = DONE;
                    if (!bus_we_q) begin
                        rdata3_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            lsu_done_q  <= 1'b0;
            bus_fault_q <= 1'b0;
            rdata3_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            lsu_done_q  <= lsu_done_d;
            bus_fault_q <= bus_fault_d;
            rdata3_q    <= rdata3_d;
        end
    end

    assign stall      = !rst && (launch || (state_q == REQ) || (state_q == WAIT));
    assign illegal    = (state_q == IDLE) && mem_req && illegal_chk;
    assign misaligned = (state_q == IDLE) && mem_req && misalign_chk;
    assign lsu_done   = lsu_done_q;
    assign bus_fault  = bus_fault_q;
    assign rdata3     = rdata3_q;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: stimulus pushes expected bus requests and
// load results, a negedge monitor compares them whenever the DUT presents them.
module tb_lsu_bus_master;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        lsu_done;
    logic [31:0] rdata3;
    logic        misaligned;
    logic        illegal;
    logic        bus_fault;

    lsu_bus_master_if bif ();

    lsu_bus_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .lsu_done   (lsu_done),
        .rdata3     (rdata3),
        .misaligned (misaligned),
        .illegal    (illegal),
        .bus_fault  (bus_fault),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rd3;
        logic        fault;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] model_rd3;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a % 4));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    // Monitor: bus request fields must match the pending expectation whenever
    // bus_req is up, and every lsu_done pulse retires one expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.bus_req) begin
                if (req_q.size() == 0) begin
                    chk("spurious_bus_req", 32'd1, 32'd0);
                end else begin
                    chk("bus_we",    {31'h0, bif.bus_we}, {31'h0, req_q[0].we});
                    chk("bus_addr",  bif.bus_addr,        req_q[0].addr);
                    chk("bus_be",    {28'h0, bif.bus_be}, {28'h0, req_q[0].be});
                    chk("bus_wdata", bif.bus_wdata,       req_q[0].wdata);
                end
            end
            if (lsu_done) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rdata3",    rdata3,              r.rd3);
                    chk("bus_fault", {31'h0, bus_fault},  {31'h0, r.fault});
                end
                if (req_q.size() > 0) void'(req_q.pop_front());
            end else if (bus_fault) begin
                chk("fault_without_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int gdly, input int rdly,
                             input logic [31:0] rd);
        int   n, reqc, since, n_sz, exp_reqc;
        bit   granted, stall_ok, to;
        req_t q;
        rsp_t r;
        n_sz     = size_bytes(f3);
        to       = (gdly + rdly) >= TIMEOUT;
        exp_reqc = (gdly + 1 < TIMEOUT) ? gdly + 1 : TIMEOUT;
        q.we     = we;
        q.addr   = a - (a % 4);
        q.be     = 4'(((1 << n_sz) - 1) << (a % 4));
        if (!we)            q.wdata = 32'h0;
        else if (n_sz == 1) q.wdata = wd[7:0] * 32'h0101_0101;
        else if (n_sz == 2) q.wdata = wd[15:0] * 32'h0001_0001;
        else                q.wdata = wd;
        if (!we) model_rd3 = to ? 32'h0 : exp_load(f3, a, rd);
        r.rd3   = model_rd3;
        r.fault = to;
        req_q.push_back(q);
        rsp_q.push_back(r);

        @(negedge clk);
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        #1;
        stall_ok = stall;
        n = 0; reqc = 0; since = 0; granted = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (lsu_done) break;
            if (!stall) stall_ok = 0;
            if (bif.bus_req) reqc++;
            bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = $urandom;
            if (granted) begin
                since++;
                if (since == rdly) begin bif.bus_rvalid = 1'b1; bif.bus_rdata = rd; end
            end else if (bif.bus_req && (reqc - 1 == gdly)) begin
                bif.bus_gnt = 1'b1; granted = 1; since = 0;
                if (rdly == 0) begin bif.bus_rvalid = 1'b1; bif.bus_rdata = rd; end
            end
        end
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
        if (n >= 64) begin
            chk("access_done_timeout", 32'd0, 32'd1);
        end else begin
            chk("stall_during_access", {31'h0, stall_ok}, 32'd1);
            chk("stall_at_done",       {31'h0, stall},    32'd0);
            chk("req_cycles",          reqc,              exp_reqc);
        end
        @(negedge clk);
        chk("no_relaunch_after_done", {31'h0, bif.bus_req}, 32'd0);
        chk("single_done_pulse",      {31'h0, lsu_done},    32'd0);
        mem_req = 1'b0;
    endtask

    task automatic check_reject(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic exp_ill, input logic exp_mis);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = $urandom;
        #1;
        chk("illegal",       {31'h0, illegal},    {31'h0, exp_ill});
        chk("misaligned",    {31'h0, misaligned}, {31'h0, exp_mis});
        chk("reject_stall",  {31'h0, stall},      32'd0);
        repeat (3) @(negedge clk);
        chk("reject_no_req", {31'h0, bif.bus_req}, 32'd0);
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h0;
        model_rd3 = 32'h0;
        #12;
        chk("rst_stall",    {31'h0, stall},       32'd0);
        chk("rst_bus_req",  {31'h0, bif.bus_req}, 32'd0);
        chk("rst_done",     {31'h0, lsu_done},    32'd0);
        chk("rst_rdata3",   rdata3,               32'h0);
        chk("rst_bus_addr", bif.bus_addr,         32'h0);
        chk("rst_bus_be",   {28'h0, bif.bus_be},  32'h0);
        @(negedge clk);
        mem_req = 1'b0; rst = 1'b0;

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80FF_FFFF);
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 2, 32'h8001_1234);
        do_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 1, 32'h5555_5555);

        check_reject(1'b0, 3'b010, 32'h101, 1'b0, 1'b1);
        check_reject(1'b0, 3'b001, 32'h103, 1'b0, 1'b1);
        check_reject(1'b0, 3'b011, 32'h100, 1'b1, 1'b0);
        check_reject(1'b1, 3'b100, 32'h100, 1'b1, 1'b0);
        check_reject(1'b0, 3'b111, 32'h100, 1'b1, 1'b0);

        // Reset in the middle of a load that is already granted.
        req_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0});
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        n = 0;
        while (!bif.bus_req && n < 8) begin @(negedge clk); n++; end
        chk("rst_case_req_seen", {31'h0, bif.bus_req}, 32'd1);
        bif.bus_gnt = 1'b1;
        @(negedge clk);
        bif.bus_gnt = 1'b0;
        @(negedge clk);
        chk("rst_case_wait_stall", {31'h0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_bus_req", {31'h0, bif.bus_req}, 32'd0);
        chk("midrst_stall",   {31'h0, stall},       32'd0);
        chk("midrst_rdata3",  rdata3,               32'h0);
        chk("midrst_done",    {31'h0, lsu_done},    32'd0);
        req_q.delete();
        model_rd3 = 32'h0;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        bif.bus_gnt = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
        chk("late_rsp_no_done",  {31'h0, lsu_done},    32'd0);
        chk("late_rsp_rdata3",   rdata3,               32'h0);
        chk("late_rsp_no_req",   {31'h0, bif.bus_req}, 32'd0);

        // Timeout boundary: completion on the last allowed cycle versus one later.
        do_access(1'b0, 3'b010, 32'h400, 32'h0, 99, 0, 32'h1111_2222);
        do_access(1'b0, 3'b010, 32'h404, 32'h0, 15, 0, 32'h3333_4444);
        do_access(1'b0, 3'b001, 32'h406, 32'h0, 14, 1, 32'h8765_0000);
        do_access(1'b0, 3'b010, 32'h408, 32'h0, 15, 1, 32'h5555_6666);
        do_access(1'b0, 3'b000, 32'h409, 32'h0, 5, 10, 32'h0000_7F00);
        do_access(1'b0, 3'b000, 32'h409, 32'h0, 5, 11, 32'h0000_7F00);
        do_access(1'b1, 3'b010, 32'h500, 32'hA5A5_5A5A, 99, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            int          sz, g, rl;
            logic [2:0]  loads[5];
            loads = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : loads[$urandom_range(0, 4)];
            sz = size_bytes(f3);
            a  = $urandom;
            a  = a - (a % sz);
            g  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            rl = $urandom_range(0, 3);
            do_access(we, f3, a, $urandom, g, rl, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", req_q.size() + rsp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit on the memory side of the write-back stage. Executes one load or store per instruction on a request/grant/response data bus.
- Stalls the pipeline until the access completes.
- Returns aligned, sign/zero-extended load data on rdata3. rdata3 is the memory input of the write-back select (wb_sel = 2'b10).
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ+WAIT before the access is aborted as a bus fault.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_req  in  1  memory instruction present in stage
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (ALU opr_res)
- wdata  in  32  store data (rs2)
- stall  out  1  hold pipeline
- lsu_done  out  1  one-cycle completion pulse
- rdata3  out  32  formatted load data, registered
- misaligned  out  1  combinational; misaligned access, no bus traffic
- illegal  out  1  combinational; invalid funct3, no bus traffic
- bus_fault  out  1  registered; high for the DONE cycle of a timed-out access
- bus_req  out  1  request valid
- bus_we  out  1  write enable
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid (loads and stores)
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; the counter clears.
  - bus_req, bus_we, lsu_done, bus_fault go to 0; rdata3 = 32'h0; bus_addr/bus_be/bus_wdata = 0.
  - stall is forced 0 while rst=1.
  - A reset mid-access drops bus_req immediately. Any later bus_gnt/bus_rvalid is ignored in IDLE.
- Checks, evaluated in IDLE:
  - funct3 in {011,110,111}, or mem_we with funct3[2]=1, gives illegal=1.
  - H with addr[0]=1, or W with addr[1:0]!=0, gives misaligned=1.
  - Either flag: no state change, stall=0, no bus request.
- Lane rules:
  - B: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: be = 4'b1111, wdata = wdata.
  - Loads drive bus_be the same way and bus_wdata = 0.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
  - IDLE: on valid mem_req, register bus_addr/be/wdata/we, funct3 and addr[1:0]. Set bus_req=1, clear the counter, go to REQ. stall is 1 combinationally in this cycle.
  - REQ: bus_req=1; all bus outputs stable until grant.
    - bus_gnt=1: drop bus_req next cycle, go to WAIT.
    - bus_gnt & bus_rvalid in the same cycle: go directly to DONE and capture data.
  - WAIT: bus_req=0. bus_rvalid=1 captures data, go to DONE.
  - DONE: stall=0, lsu_done=1 for exactly one cycle, go to IDLE. DONE never relaunches, even though mem_req is still high that cycle.
- stall = 1 in REQ and WAIT, and in IDLE with a valid mem_req; otherwise 0.
- Load formatting at capture:
  - Shift bus_rdata right by 8*addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Result registers into rdata3.
  - Stores leave rdata3 unchanged.
- Timeout:
  - The counter increments each cycle in REQ/WAIT.
  - At TIMEOUT_CYCLES without completion: bus_req=0, go to DONE with bus_fault=1 and rdata3 = 32'h0 (load) or unchanged (store).
  - bus_fault clears on leaving DONE.
  - bus_rvalid arriving exactly at the timeout cycle wins: normal completion.

Test Plan:
- LW addr=0x100, bus_gnt same cycle as req, bus_rvalid one cycle later with 0xDEADBEEF -> bus_be=1111, stall high 2 cycles, lsu_done pulse, rdata3=0xDEADBEEF.
- LB addr=0x103, bus_rdata=0x80FF_FF_FF -> bus_be=1000, rdata3=0xFFFFFF80. LBU same -> rdata3=0x00000080. LHU addr=0x102, bus_rdata=0x8001xxxx -> rdata3=0x00008001.
- SH addr=0x202, wdata=0x1234ABCD, bus_gnt delayed 3 cycles -> bus_req/addr/be=1100/bus_wdata=0xABCDABCD held stable 3 cycles, bus_we=1, rdata3 unchanged, single lsu_done.
- LW addr=0x101 and funct3=3'b011 -> misaligned=1 and illegal=1 respectively, bus_req never asserted, stall=0.
- bus_gnt never asserted, TIMEOUT_CYCLES=16 -> bus_req drops after 16 REQ cycles, bus_fault=1 and lsu_done=1 in the same cycle, rdata3=0.
- rst pulsed during WAIT, then bus_rvalid arrives -> bus_req=0 immediately, state IDLE, rdata3=0, no lsu_done, response ignored.
